// File: rtl/otp_stream_controller.sv
// One-time-pad stream controller: loads a pad store, then XORs each accepted
// message word with the next unused pad word through an internal xor_logic datapath.

module xor_logic #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c
);
  assign c = a ^ b;
endmodule

module otp_stream_controller #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_data,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [AW:0]      remaining,
  output logic             exhausted,
  output logic             error
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, EXHAUSTED} state_e;

  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pad_q [DEPTH];
  // pad_count doubles as the write pointer: slots are filled strictly in order.
  logic [AW:0]      pad_count_q, pad_count_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             error_q, error_d;
  logic             pad_we;
  logic [AW-1:0]    pad_waddr;
  logic [WIDTH-1:0] xor_result;
  logic             xfer;

  xor_logic #(.WIDTH(WIDTH)) u_xor (
    .a (in_data),
    .b (pad_q[rd_ptr_q[AW-1:0]]),
    .c (xor_result)
  );

  assign in_ready  = (state_q == RUN) && (!out_valid_q || out_ready);
  assign xfer      = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign remaining = pad_count_q - rd_ptr_q;
  assign exhausted = (state_q == EXHAUSTED);
  assign error     = error_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d     = state_q;
    pad_count_d = pad_count_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    error_d     = error_q;
    pad_we      = 1'b0;
    pad_waddr   = pad_count_q[AW-1:0];

    unique case (state_q)
      IDLE: begin
        if (load_en) begin
          pad_we      = 1'b1;
          pad_count_d = CNT_ONE;
          state_d     = LOAD;
        end else if (start) begin
          error_d = 1'b1;
        end
      end
      LOAD: begin
        if (load_en) begin
          if (pad_count_q < CNT_MAX) begin
            pad_we      = 1'b1;
            pad_count_d = pad_count_q + CNT_ONE;
          end else begin
            error_d = 1'b1;
          end
        end
        if (start) begin
          state_d  = RUN;
          rd_ptr_d = '0;
        end
      end
      RUN: begin
        if (load_en || start) error_d = 1'b1;
        if (xfer) begin
          out_data_d  = xor_result;
          out_valid_d = 1'b1;
          rd_ptr_d    = rd_ptr_q + CNT_ONE;
          if (rd_ptr_q + CNT_ONE == pad_count_q) state_d = EXHAUSTED;
        end
      end
      EXHAUSTED: begin
        if (load_en || start) error_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (clear) begin
      state_d     = IDLE;
      pad_count_d = '0;
      rd_ptr_d    = '0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      error_d     = 1'b0;
      pad_we      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pad_count_q <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pad_count_q <= pad_count_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      error_q     <= error_d;
    end
  end

  // NOTE: the pad store is deliberately reset and zeroized so no key material survives a flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pad_q[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) pad_q[i] <= '0;
    end else if (pad_we) begin
      pad_q[pad_waddr] <= load_data;
    end
  end

endmodule
